// File: rtl/fp_to_fixed.sv
// IEEE-754 single-precision to signed Q(OUT_W-FRAC_BITS).FRAC_BITS converter, one bit of alignment per cycle.
// Define FP2FIX_ROUND_EN for round-to-nearest-even; otherwise the magnitude is truncated toward zero.
module fp_to_fixed #(
  parameter int OUT_W     = 32,
  parameter int FRAC_BITS = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_sat
);

  // state | meaning
  // IDLE  | waiting for an operand, in_ready=1
  // ALIGN | shifting the magnitude one bit per cycle
  // ROUND | rounding, range check and sign application
  // OUT   | result held until out_ready
  typedef enum logic [1:0] {IDLE, ALIGN, ROUND, OUT} state_t;

  localparam int CNT_W = 8;
  localparam int MAX_RSH = 26;
  localparam logic signed [11:0] SAT_LIM = 12'(OUT_W - 25);

  state_t r_state, w_next;

  logic [OUT_W-1:0] r_mag;
  logic             r_guard;
  logic             r_sticky;
  logic [CNT_W-1:0] r_cnt;
  logic             r_left;
  logic             r_sign;
  logic             r_force_sat;
  logic [OUT_W-1:0] r_out_data;
  logic             r_out_sat;

  logic               w_sign;
  logic [7:0]         w_exp;
  logic [22:0]        w_frac;
  logic signed [11:0] w_shift;
  logic signed [11:0] w_neg;
  logic [CNT_W-1:0]   w_cnt;
  logic               w_is_zero;
  logic               w_is_special;
  logic               w_force_sat;
  logic               w_sat_neg;
  logic               w_skip_align;

  assign w_sign = in_data[31];
  assign w_exp  = in_data[30:23];
  assign w_frac = in_data[22:0];

  always_comb begin
    w_shift      = $signed({4'b0000, w_exp}) - 12'sd150 + $signed(12'(FRAC_BITS));
    w_neg        = -w_shift;
    w_is_zero    = (w_exp == 8'd0);
    w_is_special = (w_exp == 8'hFF);
    w_force_sat  = w_is_special || (!w_is_zero && (w_shift > SAT_LIM));
    // NaN always saturates positive; infinities follow their sign
    w_sat_neg    = w_sign && !(w_is_special && (w_frac != 23'd0));
    w_cnt        = '0;
    if (w_shift < 0) begin
      if (w_neg > 12'(MAX_RSH)) w_cnt = CNT_W'(MAX_RSH);
      else                      w_cnt = w_neg[CNT_W-1:0];
    end else begin
      w_cnt = w_shift[CNT_W-1:0];
    end
    w_skip_align = w_is_zero || w_force_sat || (w_cnt == '0);
  end

  logic             w_inc;
  logic [OUT_W:0]   w_mag_rnd;
  logic [OUT_W:0]   w_limit;
  logic             w_ovf;
  logic [OUT_W-1:0] w_sat_val;
  logic [OUT_W-1:0] w_result;
  logic             w_unused;

`ifdef FP2FIX_ROUND_EN
  assign w_inc = r_guard && (r_sticky || r_mag[0]);
`else
  assign w_inc = 1'b0;
`endif
  assign w_unused = &{1'b0, r_sticky, r_guard};

  always_comb begin
    w_mag_rnd = {1'b0, r_mag} + {{OUT_W{1'b0}}, w_inc};
    // a negative result may reach exactly -2^(OUT_W-1)
    w_limit   = r_sign ? {2'b01, {(OUT_W-1){1'b0}}} : {2'b00, {(OUT_W-1){1'b1}}};
    w_ovf     = r_force_sat || (w_mag_rnd > w_limit);
    w_sat_val = r_sign ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}};
    if (w_ovf)       w_result = w_sat_val;
    else if (r_sign) w_result = -w_mag_rnd[OUT_W-1:0];
    else             w_result = w_mag_rnd[OUT_W-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (in_valid) w_next = w_skip_align ? ROUND : ALIGN;
      ALIGN:   if (r_cnt == CNT_W'(1)) w_next = ROUND;
      ROUND:   w_next = OUT;
      OUT:     if (out_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (r_state == IDLE);
    out_valid = (r_state == OUT);
    out_data  = r_out_data;
    out_sat   = r_out_sat;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mag       <= '0;
      r_guard     <= 1'b0;
      r_sticky    <= 1'b0;
      r_cnt       <= '0;
      r_left      <= 1'b0;
      r_sign      <= 1'b0;
      r_force_sat <= 1'b0;
      r_out_data  <= '0;
      r_out_sat   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_guard     <= 1'b0;
            r_sticky    <= 1'b0;
            r_left      <= (w_shift > 0);
            r_force_sat <= w_force_sat;
            // zero and denormal operands flush to +0, so -0.0 also yields 0
            if (w_is_zero || w_force_sat) begin
              r_mag  <= '0;
              r_cnt  <= '0;
              r_sign <= w_force_sat ? w_sat_neg : 1'b0;
            end else begin
              r_mag  <= OUT_W'({1'b1, w_frac});
              r_cnt  <= w_cnt;
              r_sign <= w_sign;
            end
          end
        end
        ALIGN: begin
          r_cnt <= r_cnt - CNT_W'(1);
          if (r_left) begin
            r_mag <= {r_mag[OUT_W-2:0], 1'b0};
          end else begin
            r_mag    <= {1'b0, r_mag[OUT_W-1:1]};
            r_guard  <= r_mag[0];
            r_sticky <= r_sticky | r_guard;
          end
        end
        ROUND: begin
          r_out_data <= w_result;
          r_out_sat  <= w_ovf;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_to_fixed.sv
// Randomized and directed bench for fp_to_fixed (OUT_W=32, FRAC_BITS=16) against an exact-arithmetic model.
// Follows FP2FIX_ROUND_EN to choose round-to-nearest-even or truncation expectations.
module tb_fp_to_fixed;
  localparam int OUT_W = 32;
  localparam int FRAC_BITS = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_data = '0;
  logic        out_ready = 1'b0;
  logic        in_ready;
  logic        out_valid;
  logic [31:0] out_data;
  logic        out_sat;

  fp_to_fixed #(.OUT_W(OUT_W), .FRAC_BITS(FRAC_BITS)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_sat(out_sat)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // exact value mant*2^s, then rounded by integer remainder comparison
  function automatic void model(input logic [31:0] d, output logic [31:0] data,
                                output bit sat, output int lat);
    bit     sgn;
    int     e, s, n, nn;
    longint mant, q, r, half, mag;
    sgn  = d[31];
    e    = int'(d[30:23]);
    mant = longint'({1'b1, d[22:0]});
    s    = e - 150 + FRAC_BITS;
    sat  = 1'b0;
    data = '0;
    lat  = 2;
    if (e == 0) return;
    if (e == 255 || s > OUT_W - 25) begin
      sat  = 1'b1;
      data = (sgn && !(e == 255 && d[22:0] != 0)) ? 32'h8000_0000 : 32'h7FFF_FFFF;
      return;
    end
    if (s >= 0) begin
      mag = mant << s;
      lat = s + 2;
    end else begin
      n   = -s;
      lat = ((n > 26) ? 26 : n) + 2;
      nn  = (n > 40) ? 40 : n;
      q   = mant >> nn;
      r   = mant - (q << nn);
      half = longint'(1) << (nn - 1);
`ifdef FP2FIX_ROUND_EN
      if (r > half || (r == half && q[0])) q++;
`endif
      mag = q;
    end
    if (mag > (sgn ? 64'sh8000_0000 : 64'sh7FFF_FFFF)) begin
      sat  = 1'b1;
      data = sgn ? 32'h8000_0000 : 32'h7FFF_FFFF;
    end else begin
      data = sgn ? 32'(-mag) : 32'(mag);
    end
  endfunction

  logic [31:0] exp_data;
  bit          exp_sat;
  bit          mon_en = 1'b0;

  always @(negedge clk) begin
    if (mon_en && out_valid) begin
      chk("mon_out_data", out_data, exp_data);
      chk("mon_out_sat", out_sat, exp_sat);
      chk("mon_in_ready_low", in_ready, 0);
    end
  end

  task automatic do_op(input logic [31:0] d, input int hold);
    logic [31:0] ed, first;
    bit          es;
    int          lat, n, t;
    model(d, ed, es, lat);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = d;
    t = 0;
    while (!in_ready && t < 50) begin @(negedge clk); t++; end
    if (!in_ready) begin chk("accept_timeout", in_ready, 1); in_valid = 1'b0; return; end
    n = cyc + 1;
    exp_data = ed;
    exp_sat  = es;
    mon_en   = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = $urandom;
    t = 0;
    while (!out_valid && t < 60) begin @(negedge clk); t++; end
    chk("out_valid_seen", out_valid, 1);
    if (!out_valid) begin mon_en = 1'b0; return; end
    chk("latency", 64'(cyc + 1 - n), 64'(lat));
    first = out_data;
    // offer a competing operand while the result is held; it must not be taken
    if (hold > 0) begin in_valid = 1'b1; in_data = $urandom; end
    repeat (hold) begin
      @(negedge clk);
      chk("hold_stable", out_data, first);
      chk("hold_valid", out_valid, 1);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    mon_en    = 1'b0;
    chk("post_hs_valid", out_valid, 0);
    chk("post_hs_in_ready", in_ready, 1);
  endtask

  task automatic pin(input string name, input logic [31:0] d, input logic [31:0] ed,
                     input bit es, input int el);
    logic [31:0] md;
    bit          ms;
    int          ml;
    model(d, md, ms, ml);
    chk({name, "_data"}, md, ed);
    chk({name, "_sat"}, ms, es);
    chk({name, "_lat"}, 64'(ml), 64'(el));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit          seen;
    logic [31:0] d;
    int          e;

    #2;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_sat", out_sat, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_in_ready", in_ready, 1);

    pin("pin_one", 32'h3F80_0000, 32'h0001_0000, 0, 9);
    pin("pin_m2p5", 32'hC020_0000, 32'hFFFD_8000, 0, 8);
`ifdef FP2FIX_ROUND_EN
    pin("pin_tiny", 32'h3740_0000, 32'h0000_0001, 0, 26);
`else
    pin("pin_tiny", 32'h3740_0000, 32'h0000_0000, 0, 26);
`endif
    pin("pin_40k", 32'h471C_4000, 32'h7FFF_FFFF, 1, 2);
    pin("pin_ninf", 32'hFF80_0000, 32'h8000_0000, 1, 2);
    pin("pin_nan", 32'h7FC0_0000, 32'h7FFF_FFFF, 1, 2);

    do_op(32'h3F80_0000, 0);
    do_op(32'hC020_0000, 1);
    do_op(32'h3740_0000, 0);
    do_op(32'h471C_4000, 5);
    do_op(32'hFF80_0000, 0);
    do_op(32'h7FC0_0000, 2);
    do_op(32'h8000_0000, 0);
    do_op(32'h0000_0001, 0);
    do_op(32'h7F80_0000, 0);
    do_op(32'h4700_0000, 0);
    do_op(32'h46FF_FFFF, 1);
    do_op(32'hC6FF_FFFE, 0);
    do_op(32'h3F00_0000, 0);
    do_op(32'h3700_0000, 0);

    // reset in the middle of aligning 1.0
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 32'h3F80_0000;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_out_data", out_data, 0);
    chk("mid_rst_in_ready", in_ready, 1);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (20) begin @(negedge clk); seen |= out_valid; end
    chk("mid_rst_no_result", seen, 0);
    chk("mid_rst_in_ready_after", in_ready, 1);

    for (int i = 0; i < 80; i++) begin
      e = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(100, 145));
      d = {1'($urandom_range(0, 1)), 8'(e), 23'($urandom)};
      do_op(d, int'($urandom_range(0, 3)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
